branch_predict_unit: RTL and testbench

//  Parametrised successor to the ID-stage branch decision logic. Adds a direct-mapped

---
 rtl/branch_predict_unit_if.sv | 35 +++
 rtl/branch_predict_unit.sv | 121 ++++++++++++
 tb/tb_branch_predict_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Pipeline-side bundle for the branch predictor: IF lookup, ID resolution and
// redirect, plus the performance counters.
interface branch_predict_unit_if #(
  parameter int PERF_W = 16
);
  logic [31:0]       if_pc;
  logic              if_pred_taken;
  logic [31:0]       if_pred_target;
  logic              id_valid;
  logic              id_stall;
  logic [31:0]       id_pc;
  logic [1:0]        id_branch;
  logic              id_zero;
  logic [31:0]       id_target;
  logic              id_pred_taken;
  logic [31:0]       id_pred_target;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output if_pc, id_valid, id_stall, id_pc, id_branch, id_zero,
           id_target, id_pred_taken, id_pred_target,
    input  if_pred_taken, if_pred_target, redirect, redirect_pc,
           perf_branches, perf_mispred
  );

  modport slave (
    input  if_pc, id_valid, id_stall, id_pc, id_branch, id_zero,
           id_target, id_pred_taken, id_pred_target,
    output if_pred_taken, if_pred_target, redirect, redirect_pc,
           perf_branches, perf_mispred
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped 2-bit branch history table with tagged targets, looked up in IF
// and resolved/trained in ID; drives the mispredict redirect.
module branch_predict_unit #(
  parameter int         IDX_W        = 6,
  parameter bit         PREDICT_MODE = 1'b1,
  parameter logic [1:0] CNT_INIT     = 2'b01,
  parameter int         PERF_W       = 16
) (
  input logic clk,
  input logic rst_n,
  branch_predict_unit_if.slave bus
);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  logic [1:0]       cnt_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  logic [PERF_W-1:0] perf_branches_q;
  logic [PERF_W-1:0] perf_mispred_q;

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] id_tag;
  logic             if_hit;
  logic             id_tag_match;
  logic [1:0]       id_cnt;
  logic             taken;
  logic             resolve;
  logic             mispredict;
  logic             unused_pc_bits;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_tag = bus.if_pc[31:IDX_W+2];
  assign id_idx = bus.id_pc[IDX_W+1:2];
  assign id_tag = bus.id_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{bus.if_pc[1:0], bus.id_pc[1:0]};

  assign if_hit             = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bus.if_pred_taken  = PREDICT_MODE && if_hit && cnt_q[if_idx][1];
  assign bus.if_pred_target = bus.if_pred_taken ? target_q[if_idx] : 32'd0;

  assign id_tag_match = (tag_q[id_idx] == id_tag);
  assign id_cnt       = cnt_q[id_idx];

  always_comb begin
    taken = 1'b0;
    case (bus.id_branch)
      2'b01:   taken = bus.id_zero;
      2'b10:   taken = !bus.id_zero;
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign resolve    = bus.id_valid && !bus.id_stall;
  assign mispredict = resolve && ((taken != bus.id_pred_taken) ||
                      (taken && (bus.id_target != bus.id_pred_target)));

  assign bus.redirect    = mispredict;
  assign bus.redirect_pc = !mispredict ? 32'd0 :
                           (taken ? bus.id_target : bus.id_pc + 32'd4);

  // A freshly allocated taken branch starts weakly-taken rather than inheriting
  // the counter of whatever branch previously owned the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i]    <= CNT_INIT;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (PREDICT_MODE && resolve) begin
      case (bus.id_branch)
        2'b00: begin
          if (bus.id_pred_taken && id_tag_match)
            valid_q[id_idx] <= 1'b0;
        end
        2'b11: begin
          valid_q[id_idx]  <= 1'b1;
          tag_q[id_idx]    <= id_tag;
          target_q[id_idx] <= bus.id_target;
          cnt_q[id_idx]    <= 2'b11;
        end
        default: begin
          if (taken) begin
            valid_q[id_idx]  <= 1'b1;
            tag_q[id_idx]    <= id_tag;
            target_q[id_idx] <= bus.id_target;
            if (!id_tag_match)
              cnt_q[id_idx] <= 2'b10;
            else if (id_cnt != 2'b11)
              cnt_q[id_idx] <= id_cnt + 2'd1;
          end else if (id_tag_match && (id_cnt != 2'b00)) begin
            cnt_q[id_idx] <= id_cnt - 2'd1;
          end
        end
      endcase
    end
  end

  // Both counters stick at all-ones so long runs never read back as small values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
    end else begin
      if (resolve && (bus.id_branch != 2'b00) && (perf_branches_q != '1))
        perf_branches_q <= perf_branches_q + 1'b1;
      if (mispredict && (perf_mispred_q != '1))
        perf_mispred_q <= perf_mispred_q + 1'b1;
    end
  end

  assign bus.perf_branches = perf_branches_q;
  assign bus.perf_mispred  = perf_mispred_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed-vector bench for branch_predict_unit: a dynamic instance with 4-bit
// perf counters and a static-mode instance, checked through an expectation queue.
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  branch_predict_unit_if #(.PERF_W(4))  dyn_bus ();
  branch_predict_unit_if #(.PERF_W(16)) sta_bus ();

  branch_predict_unit #(
    .IDX_W(6), .PREDICT_MODE(1'b1), .CNT_INIT(2'b01), .PERF_W(4)
  ) dut_dyn (
    .clk(clk), .rst_n(rst_n), .bus(dyn_bus.slave)
  );

  branch_predict_unit #(
    .IDX_W(6), .PREDICT_MODE(1'b0), .CNT_INIT(2'b01), .PERF_W(16)
  ) dut_sta (
    .clk(clk), .rst_n(rst_n), .bus(sta_bus.slave)
  );

  typedef struct {
    string       name;
    int          unit;
    logic        exp_pred;
    logic [31:0] exp_ptgt;
    logic        exp_redir;
    logic [31:0] exp_rpc;
    bit          chk_perf;
    int          exp_br;
    int          exp_mis;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic compare_val(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic        pt;
    logic [31:0] ptg;
    logic        rd;
    logic [31:0] rpc;
    int          br;
    int          mis;
    if (e.unit == 0) begin
      pt = dyn_bus.if_pred_taken; ptg = dyn_bus.if_pred_target;
      rd = dyn_bus.redirect;      rpc = dyn_bus.redirect_pc;
      br = int'(dyn_bus.perf_branches); mis = int'(dyn_bus.perf_mispred);
    end else begin
      pt = sta_bus.if_pred_taken; ptg = sta_bus.if_pred_target;
      rd = sta_bus.redirect;      rpc = sta_bus.redirect_pc;
      br = int'(sta_bus.perf_branches); mis = int'(sta_bus.perf_mispred);
    end
    compare_val({e.name, " pred_taken"},  {31'd0, pt}, {31'd0, e.exp_pred});
    compare_val({e.name, " pred_target"}, ptg, e.exp_ptgt);
    compare_val({e.name, " redirect"},    {31'd0, rd}, {31'd0, e.exp_redir});
    compare_val({e.name, " redirect_pc"}, rpc, e.exp_rpc);
    if (e.chk_perf) begin
      compare_val({e.name, " perf_branches"}, br,  e.exp_br);
      compare_val({e.name, " perf_mispred"},  mis, e.exp_mis);
    end
  endtask

  // Monitor: outputs are combinational on the vector held since posedge+1.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  task automatic setIdle();
    dyn_bus.if_pc = 32'd0; dyn_bus.id_valid = 1'b0; dyn_bus.id_stall = 1'b0;
    dyn_bus.id_pc = 32'd0; dyn_bus.id_branch = 2'b00; dyn_bus.id_zero = 1'b0;
    dyn_bus.id_target = 32'd0; dyn_bus.id_pred_taken = 1'b0; dyn_bus.id_pred_target = 32'd0;
    sta_bus.if_pc = 32'd0; sta_bus.id_valid = 1'b0; sta_bus.id_stall = 1'b0;
    sta_bus.id_pc = 32'd0; sta_bus.id_branch = 2'b00; sta_bus.id_zero = 1'b0;
    sta_bus.id_target = 32'd0; sta_bus.id_pred_taken = 1'b0; sta_bus.id_pred_target = 32'd0;
  endtask

  task automatic applyStimulus(
    input int unit, input string name, input logic [31:0] if_pc,
    input logic v, input logic s, input logic [31:0] pc, input logic [1:0] br,
    input logic z, input logic [31:0] tgt, input logic pt, input logic [31:0] ptg,
    input logic e_pred, input logic [31:0] e_ptgt, input logic e_redir,
    input logic [31:0] e_rpc, input bit chk, input int e_br, input int e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    if (unit == 0) begin
      dyn_bus.if_pc = if_pc; dyn_bus.id_valid = v; dyn_bus.id_stall = s;
      dyn_bus.id_pc = pc; dyn_bus.id_branch = br; dyn_bus.id_zero = z;
      dyn_bus.id_target = tgt; dyn_bus.id_pred_taken = pt; dyn_bus.id_pred_target = ptg;
      sta_bus.id_valid = 1'b0;
    end else begin
      sta_bus.if_pc = if_pc; sta_bus.id_valid = v; sta_bus.id_stall = s;
      sta_bus.id_pc = pc; sta_bus.id_branch = br; sta_bus.id_zero = z;
      sta_bus.id_target = tgt; sta_bus.id_pred_taken = pt; sta_bus.id_pred_target = ptg;
      dyn_bus.id_valid = 1'b0;
    end
    e.name = name; e.unit = unit; e.exp_pred = e_pred; e.exp_ptgt = e_ptgt;
    e.exp_redir = e_redir; e.exp_rpc = e_rpc; e.chk_perf = chk;
    e.exp_br = e_br; e.exp_mis = e_mis;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t r;
    int   drain;
    rst_n = 1'b0;
    setIdle();
    dyn_bus.if_pc = 32'h40;
    #2;
    r.name = "reset_dyn"; r.unit = 0; r.exp_pred = 1'b0; r.exp_ptgt = 32'd0;
    r.exp_redir = 1'b0; r.exp_rpc = 32'd0; r.chk_perf = 1'b1; r.exp_br = 0; r.exp_mis = 0;
    checkOutput(r);
    r.name = "reset_sta"; r.unit = 1;
    checkOutput(r);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Training a beq towards strongly taken, then back down
    applyStimulus(0, "t1_first",  32'h40, 1, 0, 32'h40, 2'b01, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h100, 1, 0, 0);
    applyStimulus(0, "t1_second", 32'h40, 1, 0, 32'h40, 2'b01, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 1, 1);
    applyStimulus(0, "t1_third",  32'h40, 1, 0, 32'h40, 2'b01, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h0,   0, 0, 0);
    applyStimulus(0, "t1_fourth", 32'h40, 1, 0, 32'h40, 2'b01, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 3, 1);
    applyStimulus(0, "t2_nt1",    32'h40, 1, 0, 32'h40, 2'b01, 0, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h44,  0, 0, 0);
    applyStimulus(0, "t2_nt2",    32'h40, 1, 0, 32'h40, 2'b01, 0, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h44,  0, 0, 0);
    applyStimulus(0, "t2_check",  32'h40, 0, 0, 32'h40, 2'b01, 0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 6, 3);

    // jr target change
    applyStimulus(0, "t3_jr1",    32'h80, 1, 0, 32'h80, 2'b11, 0, 32'h1000, 0, 32'h0,    0, 32'h0,    1, 32'h1000, 0, 0, 0);
    applyStimulus(0, "t3_jr2",    32'h80, 1, 0, 32'h80, 2'b11, 0, 32'h2000, 1, 32'h1000, 1, 32'h1000, 1, 32'h2000, 0, 0, 0);
    applyStimulus(0, "t3_check",  32'h80, 0, 0, 32'h80, 2'b11, 0, 32'h2000, 0, 32'h0,    1, 32'h2000, 0, 32'h0,    1, 8, 5);

    // Aliasing, stall/bubble gating, predicted-taken non-branch
    applyStimulus(0, "t4_train",  32'h40, 1, 0, 32'h40,  2'b01, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 0, 0);
    applyStimulus(0, "t4_alias",  32'h40, 1, 0, 32'h140, 2'b10, 1, 32'h300, 0, 32'h0,   1, 32'h100, 0, 32'h0,   0, 0, 0);
    applyStimulus(0, "t4_stall",  32'h40, 1, 1, 32'h140, 2'b10, 0, 32'h300, 0, 32'h0,   1, 32'h100, 0, 32'h0,   0, 0, 0);
    applyStimulus(0, "t4_bubble", 32'h40, 0, 0, 32'h40,  2'b01, 0, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h0,   1, 10, 6);
    applyStimulus(0, "t4_nonbr",  32'h40, 1, 0, 32'h40,  2'b00, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 32'h44,  0, 0, 0);
    applyStimulus(0, "t4_inval",  32'h40, 0, 0, 32'h40,  2'b00, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 10, 7);

    // Saturating perf counters
    for (int i = 0; i < 10; i++)
      applyStimulus(0, "t5_mis", 32'h80, 1, 0, 32'hC0, 2'b11, 0, 32'h3000, 0, 32'h0, 1, 32'h2000, 1, 32'h3000, 0, 0, 0);
    applyStimulus(0, "t5_sat",    32'h80, 0, 0, 32'hC0, 2'b11, 0, 32'h3000, 0, 32'h0, 1, 32'h2000, 0, 32'h0, 1, 15, 15);

    // Asynchronous reset clears tables and counters without a clock edge
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    r.name = "t5_reset"; r.unit = 0; r.exp_pred = 1'b0; r.exp_ptgt = 32'd0;
    r.exp_redir = 1'b0; r.exp_rpc = 32'd0; r.chk_perf = 1'b1; r.exp_br = 0; r.exp_mis = 0;
    checkOutput(r);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, "t5_wrap",   32'h80, 1, 0, 32'hFFFF_FFFC, 2'b01, 0, 32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h0, 1, 0, 0);
    applyStimulus(0, "t5_after",  32'h80, 0, 0, 32'h0,         2'b00, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 32'h0, 1, 1, 1);

    // Static mode: redirect follows the actual outcome
    applyStimulus(1, "t6_beq_t1", 32'h40, 1, 0, 32'h40, 2'b01, 1, 32'h100,  0, 32'h0, 0, 32'h0, 1, 32'h100,  1, 0, 0);
    applyStimulus(1, "t6_beq_t2", 32'h40, 1, 0, 32'h40, 2'b01, 1, 32'h100,  0, 32'h0, 0, 32'h0, 1, 32'h100,  0, 0, 0);
    applyStimulus(1, "t6_bne_nt", 32'h40, 1, 0, 32'h40, 2'b10, 1, 32'h200,  0, 32'h0, 0, 32'h0, 0, 32'h0,    0, 0, 0);
    applyStimulus(1, "t6_bne_t",  32'h40, 1, 0, 32'h40, 2'b10, 0, 32'h200,  0, 32'h0, 0, 32'h0, 1, 32'h200,  0, 0, 0);
    applyStimulus(1, "t6_jr",     32'h80, 1, 0, 32'h80, 2'b11, 0, 32'h1000, 0, 32'h0, 0, 32'h0, 1, 32'h1000, 0, 0, 0);
    applyStimulus(1, "t6_beq_nt", 32'h40, 1, 0, 32'h40, 2'b01, 0, 32'h100,  0, 32'h0, 0, 32'h0, 0, 32'h0,    0, 0, 0);
    applyStimulus(1, "t6_check",  32'h40, 0, 0, 32'h40, 2'b01, 0, 32'h100,  0, 32'h0, 0, 32'h0, 0, 32'h0,    1, 6, 4);

    drain = 0;
    while (exp_q.size() > 0 && drain < 5) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
